// File: rtl/game_round_sequencer_if.sv
// Player/LFSR/score bus of the game round sequencer.
// master = environment (switches, LFSR, score display), slave = sequencer.
interface game_round_sequencer_if;
  logic       ready;
  logic [1:0] gameMode;
  logic [3:0] userGuess;
  logic [3:0] randValue;
  logic       randStep;
  logic [3:0] userCorrect;
  logic [3:0] userIncorrect;
  logic [3:0] roundCount;
  logic       playSound;
  logic       val;
  logic       gameOver;
  logic [2:0] state;

  modport master (
    output ready, gameMode, userGuess, randValue,
    input  randStep, userCorrect, userIncorrect, roundCount,
           playSound, val, gameOver, state
  );

  modport slave (
    input  ready, gameMode, userGuess, randValue,
    output randStep, userCorrect, userIncorrect, roundCount,
           playSound, val, gameOver, state
  );
endinterface

// File: rtl/game_round_sequencer.sv
// Game round sequencer: steps the LFSR, captures a target, times the guess
// window, judges the player's guess, plays a tone and keeps saturating scores.
// Optional macro MODE_RANGE_EN: range-limit the captured target to the digit
// range of the latched game mode (decimal / hex / octal).
module game_round_sequencer #(
  parameter logic [31:0] ROUND_TICKS = 32'd500_000_000,
  parameter logic [31:0] SOUND_TICKS = 32'd25_000_000,
  parameter int unsigned NUM_ROUNDS  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  game_round_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP    = 3'd1,
    CAPTURE = 3'd2,
    GUESS   = 3'd3,
    JUDGE   = 3'd4,
    SOUND   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] timer;
  logic [3:0]  target;
  logic [1:0]  mode;
  logic [3:0]  correct;
  logic [3:0]  incorrect;
  logic [3:0]  rounds;
  logic        val_q;

  // Counters stick at 15 instead of wrapping to 0.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef MODE_RANGE_EN
  // Fold a raw 4-bit LFSR value into the digit range of the game mode.
  function automatic logic [3:0] range_target(input logic [3:0] rv, input logic [1:0] m);
    case (m)
      2'b11:   return rv & 4'h7;
      2'b10:   return rv;
      default: return (rv > 4'd9) ? rv - 4'd10 : rv;
    endcase
  endfunction
`else
  // Mode is still latched for debug visibility but does not shape the target.
  logic unused_mode;
  assign unused_mode = ^mode;
`endif

  // State register; any illegal code falls back to IDLE via next-state logic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping ready aborts any active round.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ready) state_d = STEP;
      STEP:    state_d = bus.ready ? CAPTURE : IDLE;
      CAPTURE: state_d = bus.ready ? GUESS : IDLE;
      GUESS: begin
        if (!bus.ready)                          state_d = IDLE;
        else if (timer == ROUND_TICKS - 32'd1)   state_d = JUDGE;
      end
      JUDGE:   state_d = bus.ready ? SOUND : IDLE;
      SOUND: begin
        if (!bus.ready)                          state_d = IDLE;
        else if (timer == SOUND_TICKS - 32'd1)   state_d = (rounds == LAST_ROUND) ? DONE : STEP;
      end
      DONE:    if (!bus.ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer, target capture, mode latch and score keeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer     <= 32'd0;
      target    <= 4'd0;
      mode      <= 2'd0;
      correct   <= 4'd0;
      incorrect <= 4'd0;
      rounds    <= 4'd0;
      val_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timer <= 32'd0;
          if (bus.ready) begin
            mode      <= bus.gameMode;
            correct   <= 4'd0;
            incorrect <= 4'd0;
            rounds    <= 4'd0;
          end
        end
        CAPTURE: begin
          timer <= 32'd0;
`ifdef MODE_RANGE_EN
          target <= range_target(bus.randValue, mode);
`else
          target <= bus.randValue;
`endif
        end
        GUESS, SOUND: timer <= bus.ready ? timer + 32'd1 : 32'd0;
        JUDGE: begin
          timer <= 32'd0;
          if (bus.ready) begin
            rounds <= sat_inc(rounds);
            if (bus.userGuess == target) begin
              correct <= sat_inc(correct);
              val_q   <= 1'b0;
            end else begin
              incorrect <= sat_inc(incorrect);
              val_q     <= 1'b1;
            end
          end
        end
        default: timer <= 32'd0;
      endcase
    end
  end

  assign bus.randStep      = (state_q == STEP);
  assign bus.playSound     = (state_q == SOUND);
  assign bus.gameOver      = (state_q == DONE);
  assign bus.val           = val_q;
  assign bus.userCorrect   = correct;
  assign bus.userIncorrect = incorrect;
  assign bus.roundCount    = rounds;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench for game_round_sequencer: small-timing DUT for round
// flow, abort and reset; a second 15-round DUT for score saturation.
module tb_game_round_sequencer;
  localparam int RT = 4, ST = 2, NR = 3;
  localparam int L  = RT + ST + 3;   // cycles per round: STEP, CAPTURE, GUESS, JUDGE, SOUND
`ifdef MODE_RANGE_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  game_round_sequencer_if bus_a ();
  game_round_sequencer_if bus_b ();

  game_round_sequencer #(.ROUND_TICKS(32'd4), .SOUND_TICKS(32'd2), .NUM_ROUNDS(3))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  game_round_sequencer #(.ROUND_TICKS(32'd1), .SOUND_TICKS(32'd1), .NUM_ROUNDS(15))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  always #5 clock = ~clock;

  // Target the player must match, straight from the game rules.
  function automatic logic [3:0] model_target(input logic [3:0] rv, input logic [1:0] m);
    if (!RANGE_ON) return rv;
    if (m == 2'b11) return rv % 4'd8;
    if (m == 2'b10) return rv;
    return (rv >= 4'd10) ? rv - 4'd10 : rv;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if (bus_a.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus_a.state); end
    checks++; if ({bus_a.userCorrect, bus_a.userIncorrect, bus_a.roundCount} !== 12'd0) begin errors++; $display("FAIL reset_scores: got %h expected 000", {bus_a.userCorrect, bus_a.userIncorrect, bus_a.roundCount}); end
    checks++; if ({bus_a.randStep, bus_a.playSound, bus_a.val, bus_a.gameOver} !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus_a.randStep, bus_a.playSound, bus_a.val, bus_a.gameOver}); end
    checks++; if (bus_b.state !== 3'd0) begin errors++; $display("FAIL reset_state_b: got %0d expected 0", bus_b.state); end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++; if (bus_a.state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", bus_a.state); end
    end
  endtask

  task automatic test_timing();
    int exp_q[$];
    for (int r = 0; r < NR; r++) begin
      exp_q.push_back(1); exp_q.push_back(2);
      repeat (RT) exp_q.push_back(3);
      exp_q.push_back(4);
      repeat (ST) exp_q.push_back(5);
    end
    exp_q.push_back(6);
    @(negedge clock);
    bus_a.randValue = 4'($urandom); bus_a.userGuess = 4'($urandom);
    bus_a.gameMode = 2'($urandom); bus_a.ready = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      checks++; if (bus_a.state !== 3'(exp_q[i])) begin errors++; $display("FAIL seq_state cyc%0d: got %0d expected %0d", i + 1, bus_a.state, exp_q[i]); end
      checks++; if (bus_a.randStep !== (exp_q[i] == 1)) begin errors++; $display("FAIL seq_randstep cyc%0d: got %b expected %b", i + 1, bus_a.randStep, exp_q[i] == 1); end
      checks++; if (bus_a.playSound !== (exp_q[i] == 5)) begin errors++; $display("FAIL seq_sound cyc%0d: got %b expected %b", i + 1, bus_a.playSound, exp_q[i] == 5); end
      checks++; if (bus_a.gameOver !== (exp_q[i] == 6)) begin errors++; $display("FAIL seq_over cyc%0d: got %b expected %b", i + 1, bus_a.gameOver, exp_q[i] == 6); end
    end
    bus_a.ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.state !== 3'd0) begin errors++; $display("FAIL seq_rearm: got %0d expected 0", bus_a.state); end
  endtask

  // Full game on DUT A; gameMode is scrambled after the start to show it is ignored.
  task automatic play_game(input logic [1:0] mode, input logic [3:0] rvs [NR], input logic [3:0] gss [NR]);
    int exp_c, exp_i;
    logic exp_val;
    logic [3:0] tgt;
    exp_c = 0; exp_i = 0; exp_val = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.state !== 3'd0) begin errors++; $display("FAIL game_start_idle: got %0d expected 0", bus_a.state); end
    bus_a.gameMode = mode; bus_a.ready = 1'b1;
    for (int r = 0; r < NR; r++) begin
      bus_a.randValue = rvs[r]; bus_a.userGuess = gss[r];
      tgt = model_target(rvs[r], mode);
      repeat (L - 1) begin @(negedge clock); bus_a.gameMode = 2'($urandom); end
      if (gss[r] == tgt) exp_c++; else exp_i++;
      exp_val = (gss[r] != tgt);
      checks++; if (bus_a.userCorrect !== 4'(exp_c)) begin errors++; $display("FAIL game_correct r%0d: got %0d expected %0d", r, bus_a.userCorrect, exp_c); end
      checks++; if (bus_a.userIncorrect !== 4'(exp_i)) begin errors++; $display("FAIL game_incorrect r%0d: got %0d expected %0d", r, bus_a.userIncorrect, exp_i); end
      checks++; if (bus_a.val !== exp_val) begin errors++; $display("FAIL game_val r%0d: got %b expected %b", r, bus_a.val, exp_val); end
      checks++; if (bus_a.roundCount !== 4'(r + 1)) begin errors++; $display("FAIL game_rounds r%0d: got %0d expected %0d", r, bus_a.roundCount, r + 1); end
      @(negedge clock);
    end
    @(negedge clock);
    repeat (3) begin
      checks++; if (bus_a.gameOver !== 1'b1 || bus_a.state !== 3'd6) begin errors++; $display("FAIL game_done: got over=%b state=%0d expected over=1 state=6", bus_a.gameOver, bus_a.state); end
      checks++; if (bus_a.userCorrect !== 4'(exp_c) || bus_a.playSound !== 1'b0) begin errors++; $display("FAIL game_done_hold: got correct=%0d sound=%b expected %0d,0", bus_a.userCorrect, bus_a.playSound, exp_c); end
      @(negedge clock);
    end
    bus_a.ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.state !== 3'd0 || bus_a.gameOver !== 1'b0) begin errors++; $display("FAIL game_rearm: got state=%0d over=%b expected 0,0", bus_a.state, bus_a.gameOver); end
    checks++; if (bus_a.userIncorrect !== 4'(exp_i)) begin errors++; $display("FAIL game_retain: got %0d expected %0d", bus_a.userIncorrect, exp_i); end
  endtask

  task automatic test_all_correct();
    logic [3:0] rvs [NR];
    logic [3:0] gss [NR];
    for (int r = 0; r < NR; r++) begin rvs[r] = 4'd5; gss[r] = 4'd5; end
    play_game(2'($urandom), rvs, gss);
    checks++; if (bus_a.userCorrect !== 4'd3 || bus_a.val !== 1'b0) begin errors++; $display("FAIL all_correct: got correct=%0d val=%b expected 3,0", bus_a.userCorrect, bus_a.val); end
  endtask

  task automatic test_random_games(input int n);
    logic [3:0] rvs [NR];
    logic [3:0] gss [NR];
    logic [1:0] mode;
    for (int g = 0; g < n; g++) begin
      mode = 2'($urandom);
      for (int r = 0; r < NR; r++) begin
        rvs[r] = 4'($urandom);
        gss[r] = ($urandom_range(0, 1) == 1) ? model_target(rvs[r], mode) : 4'($urandom);
      end
      play_game(mode, rvs, gss);
    end
  endtask

  task automatic test_mode_range();
    logic [3:0] rvs [NR];
    logic [3:0] gss [NR];
    for (int r = 0; r < NR; r++) begin rvs[r] = 4'd13; gss[r] = 4'd5; end
    play_game(2'b11, rvs, gss);
    checks++; if (bus_a.userCorrect !== (RANGE_ON ? 4'd3 : 4'd0)) begin errors++; $display("FAIL mode_range: got correct=%0d expected %0d", bus_a.userCorrect, RANGE_ON ? 3 : 0); end
  endtask

  // Drop ready at negedge m (counted from the start edge) during round 1.
  task automatic abort_at(input int m, input string tag);
    logic [3:0] rv0, rv1;
    int exp_rounds, exp_c;
    rv0 = 4'($urandom); rv1 = 4'($urandom);
    @(negedge clock);
    bus_a.gameMode = 2'b10; bus_a.ready = 1'b1;
    for (int c = 0; c < m; c++) begin
      if (c == 0) begin bus_a.randValue = rv0; bus_a.userGuess = rv0; end
      if (c == L) begin bus_a.randValue = rv1; bus_a.userGuess = ~rv1; end
      @(negedge clock);
    end
    exp_rounds = (m >= L + 8) ? 2 : 1;
    exp_c = 1;
    bus_a.ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.state !== 3'd0 || bus_a.playSound !== 1'b0 || bus_a.randStep !== 1'b0) begin errors++; $display("FAIL %s_idle: got state=%0d sound=%b step=%b expected 0,0,0", tag, bus_a.state, bus_a.playSound, bus_a.randStep); end
    checks++; if (bus_a.roundCount !== 4'(exp_rounds)) begin errors++; $display("FAIL %s_rounds: got %0d expected %0d", tag, bus_a.roundCount, exp_rounds); end
    checks++; if (bus_a.userCorrect !== 4'(exp_c) || bus_a.userIncorrect !== 4'(exp_rounds - exp_c)) begin errors++; $display("FAIL %s_scores: got %0d/%0d expected %0d/%0d", tag, bus_a.userCorrect, bus_a.userIncorrect, exp_c, exp_rounds - exp_c); end
    repeat (2) @(negedge clock);
    checks++; if (bus_a.state !== 3'd0 || bus_a.roundCount !== 4'(exp_rounds)) begin errors++; $display("FAIL %s_stay: got state=%0d rounds=%0d expected 0,%0d", tag, bus_a.state, bus_a.roundCount, exp_rounds); end
  endtask

  task automatic test_abort();
    int m;
    abort_at(L + 8, "abort_sound");
    for (int k = 0; k < 4; k++) begin
      do m = L + int'($urandom_range(1, 9)); while (m == L + 7);
      abort_at(m, "abort_rand");
    end
  endtask

  task automatic test_reset_mid_round();
    @(negedge clock);
    bus_a.gameMode = 2'b10; bus_a.randValue = 4'd9; bus_a.userGuess = 4'd9; bus_a.ready = 1'b1;
    repeat (L + 4) @(negedge clock);
    checks++; if (bus_a.state !== 3'd3 || bus_a.roundCount !== 4'd1) begin errors++; $display("FAIL pre_reset: got state=%0d rounds=%0d expected 3,1", bus_a.state, bus_a.roundCount); end
    reset = 1'b1;
    #1;
    checks++; if (bus_a.state !== 3'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", bus_a.state); end
    checks++; if ({bus_a.userCorrect, bus_a.userIncorrect, bus_a.roundCount, bus_a.randStep, bus_a.playSound, bus_a.val, bus_a.gameOver} !== 16'd0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0000", {bus_a.userCorrect, bus_a.userIncorrect, bus_a.roundCount, bus_a.randStep, bus_a.playSound, bus_a.val, bus_a.gameOver}); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.state !== 3'd1 || bus_a.randStep !== 1'b1) begin errors++; $display("FAIL restart_step: got state=%0d step=%b expected 1,1", bus_a.state, bus_a.randStep); end
    bus_a.ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_saturation();
    logic [3:0] rv;
    logic [3:0] prev;
    int cycles;
    bit ok_mono;
    rv = 4'($urandom);
    @(negedge clock);
    bus_b.gameMode = 2'b10; bus_b.randValue = rv; bus_b.userGuess = ~rv; bus_b.ready = 1'b1;
    prev = 4'd0; cycles = 0; ok_mono = 1'b1;
    while (bus_b.gameOver !== 1'b1 && cycles < 200) begin
      @(negedge clock);
      cycles++;
      if (bus_b.userIncorrect < prev) ok_mono = 1'b0;
      prev = bus_b.userIncorrect;
    end
    checks++; if (cycles >= 200) begin errors++; $display("FAIL sat_timeout: got %0d cycles expected gameOver before 200", cycles); end
    checks++; if (!ok_mono) begin errors++; $display("FAIL sat_wrap: got a decreasing userIncorrect expected monotonic"); end
    checks++; if (bus_b.userIncorrect !== 4'd15 || bus_b.userCorrect !== 4'd0) begin errors++; $display("FAIL sat_scores: got %0d/%0d expected 0/15", bus_b.userCorrect, bus_b.userIncorrect); end
    checks++; if (bus_b.roundCount !== 4'd15 || bus_b.val !== 1'b1) begin errors++; $display("FAIL sat_rounds: got rounds=%0d val=%b expected 15,1", bus_b.roundCount, bus_b.val); end
    bus_b.ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_b.state !== 3'd0 || bus_b.userIncorrect !== 4'd15) begin errors++; $display("FAIL sat_rearm: got state=%0d incorrect=%0d expected 0,15", bus_b.state, bus_b.userIncorrect); end
  endtask

  initial begin
    bus_a.ready = 1'b0; bus_a.gameMode = 2'd0; bus_a.userGuess = 4'd0; bus_a.randValue = 4'd0;
    bus_b.ready = 1'b0; bus_b.gameMode = 2'd0; bus_b.userGuess = 4'd0; bus_b.randValue = 4'd0;
    test_reset();
    test_timing();
    test_all_correct();
    test_random_games(6);
    test_mode_range();
    test_abort();
    test_reset_mid_round();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
